// File: rtl/rot_arbiter_if.sv
// ----------------------------------------------------------------------------
// rot_arbiter_if
//   Bundles every signal between the two rotate requesters, the result
//   consumer and the shared rotate unit. Clock and reset are not part of
//   the bundle.
//
//   Requester side (one set per port, n = 0/1):
//     reqn   request; held high until gntn
//     inn    16-bit operand
//     cntn   4-bit rotate amount
//     dirn   direction: 0 = left, 1 = right
//     gntn   operands accepted this cycle (1-cycle pulse)
//   Result side:
//     out_valid  result available
//     out_data   rotated result
//     out_id     requester that owns out_data
//     out_ready  consumer accepts the result while out_valid = 1
//   Status:
//     busy       an operation is in flight or waiting to be consumed
//
//   modport slave  : the arbiter itself
//   modport master : the requesters / consumer driving the arbiter
// ----------------------------------------------------------------------------
interface rot_arbiter_if;
    logic        req0;
    logic [15:0] in0;
    logic [3:0]  cnt0;
    logic        dir0;
    logic        gnt0;

    logic        req1;
    logic [15:0] in1;
    logic [3:0]  cnt1;
    logic        dir1;
    logic        gnt1;

    logic        out_valid;
    logic [15:0] out_data;
    logic        out_id;
    logic        out_ready;

    logic        busy;

    modport slave (
        input  req0, in0, cnt0, dir0,
        input  req1, in1, cnt1, dir1,
        input  out_ready,
        output gnt0, gnt1,
        output out_valid, out_data, out_id,
        output busy
    );

    modport master (
        output req0, in0, cnt0, dir0,
        output req1, in1, cnt1, dir1,
        output out_ready,
        input  gnt0, gnt1,
        input  out_valid, out_data, out_id,
        input  busy
    );
endinterface

// File: rtl/rot_arbiter.sv
// ----------------------------------------------------------------------------
// rot_arbiter
//   Shares one 16-bit left rotator between two requesters. A round-robin
//   pointer picks the winner when both request together; the winner's
//   operand, amount, direction and id are captured, rotated in the next
//   cycle and the result is held until the consumer takes it.
//
//   Operation flow: IDLE (grant + capture) -> ROT (rotate, register result)
//                   -> DONE (hold result until out_ready) -> IDLE
//   A result appears on out_valid two cycles after the grant cycle, so an
//   operation takes at least three cycles.
//
//   Parameters:
//     RESET_PRIO  requester that holds priority after reset (0 or 1)
//   Ports:
//     clk   system clock, all state changes on the rising edge
//     rst   synchronous, active-high reset; discards any in-flight operation
//     bus   rot_arbiter_if.slave, request/grant inputs and result outputs
//
//   Also contains left_rotator, the shared 16-bit rotate datapath.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// left_rotator
//   Purely combinational 16-bit rotate-left by 0..15 positions, built as a
//   four-stage logarithmic barrel (1, 2, 4, 8 positions).
//   Ports:
//     data_i  operand
//     amt_i   rotate-left amount
//     data_o  rotated operand
// ----------------------------------------------------------------------------
module left_rotator (
    input  logic [15:0] data_i,
    input  logic [3:0]  amt_i,
    output logic [15:0] data_o
);
    logic [15:0] stage1;
    logic [15:0] stage2;
    logic [15:0] stage4;

    assign stage1 = amt_i[0] ? {data_i[14:0], data_i[15]}    : data_i;
    assign stage2 = amt_i[1] ? {stage1[13:0], stage1[15:14]} : stage1;
    assign stage4 = amt_i[2] ? {stage2[11:0], stage2[15:12]} : stage2;
    assign data_o = amt_i[3] ? {stage4[7:0],  stage4[15:8]}  : stage4;
endmodule

module rot_arbiter #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    rot_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q,  prio_d;    // port that wins when both request
    logic [15:0] opnd_q,  opnd_d;    // captured operand
    logic [3:0]  amt_q,   amt_d;     // captured rotate-left amount
    logic        op_id_q, op_id_d;   // owner of the operation in flight
    logic [15:0] data_q,  data_d;    // result presented on out_data
    logic        id_q,    id_d;      // owner presented on out_id

    logic        any_req;
    logic        win_id;
    logic        grant;
    logic [15:0] win_in;
    logic [3:0]  win_cnt;
    logic        win_dir;
    logic [3:0]  win_amt;
    logic [15:0] rot_res;

    // ------------------------------------------------------------------
    // Arbitration. A lone requester always wins; the pointer only breaks
    // ties. Grants exist only in IDLE and are suppressed during reset so
    // a requester never sees a grant for an operation that is not taken.
    // ------------------------------------------------------------------
    assign any_req = bus.req0 | bus.req1;
    assign win_id  = (bus.req0 & bus.req1) ? prio_q : bus.req1;
    assign grant   = (state_q == S_IDLE) & any_req & ~rst;

    assign bus.gnt0 = grant & ~win_id;
    assign bus.gnt1 = grant &  win_id;

    assign win_in  = win_id ? bus.in1  : bus.in0;
    assign win_cnt = win_id ? bus.cnt1 : bus.cnt0;
    assign win_dir = win_id ? bus.dir1 : bus.dir0;

    // A right rotate by n equals a left rotate by (16 - n) mod 16, which is
    // the 4-bit two's complement of n; n = 0 stays 0 in both directions.
    assign win_amt = win_dir ? (~win_cnt + 4'd1) : win_cnt;

    left_rotator u_rot (
        .data_i (opnd_q),
        .amt_i  (amt_q),
        .data_o (rot_res)
    );

    // ------------------------------------------------------------------
    // Next-state and capture logic.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        prio_d  = prio_q;
        opnd_d  = opnd_q;
        amt_d   = amt_q;
        op_id_d = op_id_q;
        data_d  = data_q;
        id_d    = id_q;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    opnd_d  = win_in;
                    amt_d   = win_amt;
                    op_id_d = win_id;
                    prio_d  = ~win_id;   // loser of this round goes first next
                    state_d = S_ROT;
                end
            end
            S_ROT: begin
                // Result and owner move to the outputs together so out_id
                // never refers to a different result than out_data.
                data_d  = rot_res;
                id_d    = op_id_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset along with the control
        // state because out_data and out_id are visible outputs whose
        // post-reset value is defined as zero.
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= RESET_PRIO;
            opnd_q  <= 16'h0000;
            amt_q   <= 4'd0;
            op_id_q <= 1'b0;
            data_q  <= 16'h0000;
            id_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample its
            // _d value from the same edge, independent of statement order.
            state_q <= state_d;
            prio_q  <= prio_d;
            opnd_q  <= opnd_d;
            amt_q   <= amt_d;
            op_id_q <= op_id_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_rot_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rot_arbiter
//   Self-checking bench for rot_arbiter (RESET_PRIO = 0). Inputs are driven
//   on the falling clock edge and outputs sampled 1 ns later. Expected values
//   come from hand-written vectors and from a rotate/round-robin reference
//   model written directly from the rotate and arbitration rules.
// ----------------------------------------------------------------------------
module tb_rot_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rot_arbiter_if bus ();

    rot_arbiter #(
        .RESET_PRIO (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit prio;   // model of the tie-break pointer

    typedef struct {
        bit          r0;
        bit          r1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [3:0]  c0;
        logic [3:0]  c1;
        bit          di0;
        bit          di1;
        int          stall;
        logic [15:0] exp_data;
        bit          exp_id;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Rotation by arithmetic on a widened word: left moves bits up and wraps
    // the top k bits to the bottom, right does the mirror image.
    function automatic logic [15:0] ref_rot(input logic [15:0] x, input int unsigned n, input bit right);
        int unsigned k;
        logic [31:0] w;
        k = n % 16;
        w = {16'h0000, x};
        if (k == 0) return x;
        if (!right) return 16'((w << k) | (w >> (16 - k)));
        return 16'((w >> k) | (w << (16 - k)));
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        check("reset gnt0", 32'(bus.gnt0), 32'(0));
        check("reset gnt1", 32'(bus.gnt1), 32'(0));
        repeat (cycles - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'(0));
        check("reset out_data",  32'(bus.out_data),  32'(0));
        check("reset out_id",    32'(bus.out_id),    32'(0));
        check("reset busy",      32'(bus.busy),      32'(0));
        prio = 1'b0;
    endtask

    // One complete operation, starting in IDLE. Requests stay high through
    // ROT and DONE to show grants stay low there; they drop in the last DONE
    // cycle so the return to IDLE is quiet.
    task automatic run_op(input bit r0, input bit r1,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [3:0] c0, input logic [3:0] c1,
                          input bit di0, input bit di1, input int stall,
                          input logic [15:0] exp_data, input bit exp_id,
                          input string tag);
        @(negedge clk);
        bus.req0 = r0;   bus.req1 = r1;
        bus.in0  = d0;   bus.in1  = d1;
        bus.cnt0 = c0;   bus.cnt1 = c1;
        bus.dir0 = di0;  bus.dir1 = di1;
        bus.out_ready = (stall == 0);
        #1;
        check({tag, " gnt0"}, 32'(bus.gnt0), 32'(!exp_id));
        check({tag, " gnt1"}, 32'(bus.gnt1), 32'(exp_id));
        prio = !exp_id;

        @(negedge clk);
        #1;
        check({tag, " rot busy"},  32'(bus.busy),              32'(1));
        check({tag, " rot valid"}, 32'(bus.out_valid),         32'(0));
        check({tag, " rot gnt"},   32'(bus.gnt0 | bus.gnt1),   32'(0));

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            bus.out_ready = (s == stall);
            if (s == stall) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            #1;
            check($sformatf("%s done%0d valid", tag, s), 32'(bus.out_valid), 32'(1));
            check($sformatf("%s done%0d data", tag, s),  32'(bus.out_data),  32'(exp_data));
            check($sformatf("%s done%0d id", tag, s),    32'(bus.out_id),    32'(exp_id));
            check($sformatf("%s done%0d gnt", tag, s),   32'(bus.gnt0 | bus.gnt1), 32'(0));
        end
    endtask

    initial begin
        bit          r0, r1, w, di0, di1;
        logic [15:0] d0, d1, exp;
        logic [3:0]  c0, c1;
        int          stall;

        rst = 1'b1;
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.in0  = '0;    bus.in1  = '0;
        bus.cnt0 = '0;    bus.cnt1 = '0;
        bus.dir0 = 1'b0;  bus.dir1 = 1'b0;
        bus.out_ready = 1'b1;

        // Directed vectors; expected owner follows the pointer from reset.
        vecs[0] = '{1, 0, 16'h8001, 16'h0000, 4'd1,  4'd0,  0, 0, 0, 16'h0003, 0};
        vecs[1] = '{0, 1, 16'h0000, 16'h0001, 4'd0,  4'd1,  0, 1, 0, 16'h8000, 1};
        vecs[2] = '{0, 1, 16'h0000, 16'h0001, 4'd0,  4'd0,  0, 1, 1, 16'h0001, 1};
        vecs[3] = '{1, 0, 16'h1234, 16'hFFFF, 4'd4,  4'd7,  0, 0, 2, 16'h2341, 0};
        vecs[4] = '{1, 0, 16'h1234, 16'h0000, 4'd4,  4'd0,  1, 0, 0, 16'h4123, 0};
        vecs[5] = '{0, 1, 16'h0000, 16'hA5C3, 4'd0,  4'd8,  0, 0, 0, 16'hC3A5, 1};
        vecs[6] = '{1, 0, 16'h8000, 16'h0000, 4'd15, 4'd0,  0, 0, 0, 16'h4000, 0};
        vecs[7] = '{0, 1, 16'h0000, 16'h0001, 4'd0,  4'd15, 0, 1, 3, 16'h0002, 1};
        vecs[8] = '{1, 1, 16'hF00F, 16'h1111, 4'd4,  4'd1,  0, 0, 0, 16'h00FF, 0};
        vecs[9] = '{1, 1, 16'h2222, 16'hF00F, 4'd3,  4'd4,  0, 1, 1, 16'hFF00, 1};

        do_reset(3);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1,
                   vecs[i].c0, vecs[i].c1, vecs[i].di0, vecs[i].di1,
                   vecs[i].stall, vecs[i].exp_data, vecs[i].exp_id,
                   $sformatf("vec%0d", i));
        end

        // Both requesters held: grants alternate 0,1,0,1 every three cycles.
        do_reset(2);
        @(negedge clk);
        bus.req0 = 1'b1;  bus.in0 = 16'h0001;  bus.cnt0 = 4'd1;  bus.dir0 = 1'b0;
        bus.req1 = 1'b1;  bus.in1 = 16'h0001;  bus.cnt1 = 4'd2;  bus.dir1 = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("rr c%0d gnt0", c), 32'(bus.gnt0), 32'(c % 6 == 0));
            check($sformatf("rr c%0d gnt1", c), 32'(bus.gnt1), 32'(c % 6 == 3));
            check($sformatf("rr c%0d exclusive", c), 32'(bus.gnt0 & bus.gnt1), 32'(0));
            if (c % 3 == 2) begin
                check($sformatf("rr c%0d valid", c), 32'(bus.out_valid), 32'(1));
                check($sformatf("rr c%0d id", c),    32'(bus.out_id),    32'((c / 3) % 2));
                check($sformatf("rr c%0d data", c),  32'(bus.out_data),
                      32'(((c / 3) % 2) ? 16'h0004 : 16'h0002));
            end
            if (c == 11) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        prio = 1'b0;

        // Consumer stalls five cycles in DONE while port 0 keeps requesting.
        @(negedge clk);
        bus.req0 = 1'b1;  bus.in0 = 16'h00F0;  bus.cnt0 = 4'd4;  bus.dir0 = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("stall gnt0", 32'(bus.gnt0), 32'(1));
        @(negedge clk);
        #1;
        check("stall rot busy", 32'(bus.busy), 32'(1));
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            #1;
            check($sformatf("stall s%0d valid", s), 32'(bus.out_valid), 32'(1));
            check($sformatf("stall s%0d data", s),  32'(bus.out_data),  32'(16'h0F00));
            check($sformatf("stall s%0d id", s),    32'(bus.out_id),    32'(0));
            check($sformatf("stall s%0d gnt0", s),  32'(bus.gnt0),      32'(0));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("stall release valid", 32'(bus.out_valid), 32'(1));
        @(negedge clk);
        #1;
        check("stall regrant gnt0", 32'(bus.gnt0), 32'(1));
        check("stall regrant busy", 32'(bus.busy), 32'(0));
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        #1;
        check("stall second data", 32'(bus.out_data), 32'(16'h0F00));
        prio = 1'b1;

        // Reset in ROT discards the operation and restores the pointer.
        @(negedge clk);
        bus.req1 = 1'b1;  bus.in1 = 16'h1234;  bus.cnt1 = 4'd1;  bus.dir1 = 1'b0;
        #1;
        check("rstmid gnt1", 32'(bus.gnt1), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        check("rstmid in-reset gnt0", 32'(bus.gnt0), 32'(0));
        check("rstmid in-reset gnt1", 32'(bus.gnt1), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid valid", 32'(bus.out_valid), 32'(0));
        check("rstmid busy",  32'(bus.busy),      32'(0));
        check("rstmid data",  32'(bus.out_data),  32'(0));
        check("rstmid gnt0",  32'(bus.gnt0),      32'(1));
        check("rstmid gnt1",  32'(bus.gnt1),      32'(0));
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid result data", 32'(bus.out_data), 32'(ref_rot(16'h00F0, 4, 1'b0)));
        check("rstmid result id",   32'(bus.out_id),   32'(0));
        prio = 1'b1;

        // Every amount, both directions, both ports on a fixed pattern.
        for (int p = 0; p < 2; p++) begin
            for (int dr = 0; dr < 2; dr++) begin
                for (int c = 0; c < 16; c++) begin
                    run_op(p == 0, p == 1, 16'hA5C3, 16'hA5C3, 4'(c), 4'(c),
                           dr[0], dr[0], 0, ref_rot(16'hA5C3, c, dr[0]), p[0],
                           $sformatf("sweep p%0d d%0d c%0d", p, dr, c));
                end
            end
        end

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
                #1;
                check($sformatf("rand%0d idle gnt", i), 32'(bus.gnt0 | bus.gnt1), 32'(0));
                check($sformatf("rand%0d idle busy", i), 32'(bus.busy), 32'(0));
            end
            case ($urandom_range(0, 2))
                0:       begin r0 = 1'b1; r1 = 1'b0; end
                1:       begin r0 = 1'b0; r1 = 1'b1; end
                default: begin r0 = 1'b1; r1 = 1'b1; end
            endcase
            d0    = 16'($urandom);
            d1    = 16'($urandom);
            c0    = 4'($urandom);
            c1    = 4'($urandom);
            di0   = 1'($urandom);
            di1   = 1'($urandom);
            stall = int'($urandom_range(0, 3));
            w     = (r0 && r1) ? prio : r1;
            exp   = w ? ref_rot(d1, c1, di1) : ref_rot(d0, c0, di0);
            run_op(r0, r1, d0, d1, c0, c1, di0, di1, stall, exp, w,
                   $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
